// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pulls PS/2 set-2 scan-code bytes out of the ps2_keyboard
// FIFO, folds E0/F0 prefixes into single key events, tracks the held key,
// counts presses and drives an active-low 7-segment digit bank.
//
// Handshake (ready / nextdata_n): while IDLE, ready=1 means data holds a
// valid byte; that byte is consumed at the clock edge and nextdata_n is
// driven low for exactly the next cycle (POP) to pop the FIFO. ready is
// ignored during POP and next sampled in the following IDLE cycle, so at
// most one byte is taken every two clocks.
module ps2_key_decoder #(
    parameter int CNT_W         = 8,
    parameter int NUM_DIGITS    = 4,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    ready,
    input  logic [7:0]              data,
    input  logic                    overflow,
    output logic                    nextdata_n,
    output logic                    key_valid,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    key_make,
    output logic                    key_held,
    output logic [CNT_W-1:0]        press_count,
    output logic                    ovf_sticky,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } hs_state_t;

    hs_state_t   state;
    logic        ext_flag;
    logic        brk_flag;
    logic [7:0]  held_code;
    logic        held_ext;

    logic        consume;
    logic        is_e0;
    logic        is_f0;
    logic        ev_make;
    logic        held_match;
    logic        ev_repeat;

    logic [23:0]               cnt_ext;
    logic [31:0]               disp_word;
    logic [7*NUM_DIGITS-1:0]   hex_next;

    assign dbg_state = state;

    // Active-low hex glyph, segment a on bit 0 through g on bit 6.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Classify the FIFO head byte and compare it against the held key.
    always_comb begin
        consume    = (state == IDLE) && ready;
        is_e0      = (data == 8'hE0);
        is_f0      = (data == 8'hF0);
        ev_make    = ~brk_flag;
        held_match = key_held && (held_code == data) && (held_ext == ext_flag);
        ev_repeat  = (FILTER_REPEAT != 0) && held_match;
    end

    // Handshake FSM: one registered nextdata_n low cycle per consumed byte.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        state      <= POP;
                        nextdata_n <= 1'b0;
                    end
                end
                POP: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
            endcase
        end
    end

    // Prefix decode and key-event registers; event outputs land one cycle
    // after consumption, together with the nextdata_n pop strobe.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_make    <= 1'b0;
            key_held    <= 1'b0;
            press_count <= '0;
        end else begin
            key_valid <= 1'b0;
            if (consume) begin
                if (is_e0) begin
                    ext_flag <= 1'b1;
                end else if (is_f0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    // A typematic repeat of the held key is swallowed whole.
                    if (!(ev_make && ev_repeat)) begin
                        key_valid <= 1'b1;
                        key_code  <= data;
                        key_ext   <= ext_flag;
                        key_make  <= ev_make;
                        if (ev_make) begin
                            held_code   <= data;
                            held_ext    <= ext_flag;
                            key_held    <= 1'b1;
                            press_count <= press_count + CNT_W'(1);
                        end else if (held_match) begin
                            key_held <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Overflow is latched until the next reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ovf_sticky <= 1'b0;
        end else if (overflow) begin
            ovf_sticky <= 1'b1;
        end
    end

    // Display word: two key-code nibbles, then press_count nibbles (zero above CNT_W).
    always_comb begin
        cnt_ext   = {{(24-CNT_W){1'b0}}, press_count};
        disp_word = {cnt_ext, key_code};
        hex_next  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_next[7*i +: 7] = seg7(4'(disp_word >> (4*i)));
        end
    end

    // Registered digit drive; reset shows "0" on every digit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hex <= {NUM_DIGITS{7'b1000000}};
        end else begin
            hex <= hex_next;
        end
    end

endmodule
